// File: rtl/result_serializer.sv
// result_serializer: unloads a parallel result word as MSB-first
// Chunk_Width-bit beats over a valid/ready stream, then pulses done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for load; load_ready high
// SEND  | presenting beats; one transfers per out_valid & out_ready edge
// DONE  | one-cycle done pulse after the final beat; back to IDLE next
module result_serializer #(
    parameter int Word_Length = 34,
    parameter int Chunk_Width = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sys_reset,
    input  logic                   load,
    input  logic [Word_Length-1:0] Data_Input,
    output logic                   load_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [Chunk_Width-1:0] out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int Beats = Word_Length / Chunk_Width;
    localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    if ((Word_Length % Chunk_Width) != 0) begin : g_param_check
        $error("result_serializer: Word_Length must be a multiple of Chunk_Width");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [Word_Length-1:0] shift_q,     shift_d;
    logic [CntW-1:0]        cnt_q,       cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q,      done_d;

    // Next-state and datapath update; sys_reset overrides load and transfers.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        if (sys_reset) begin
            state_d     = S_IDLE;
            shift_d     = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        state_d     = S_SEND;
                        shift_d     = Data_Input;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        shift_d = shift_q << Chunk_Width;
                        if (cnt_q == LastCnt) begin
                            state_d     = S_DONE;
                            cnt_d       = '0;
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d     = S_IDLE;
                    shift_d     = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Outputs come straight from registers or a decode of registered state.
    assign out_valid  = out_valid_q;
    assign out_data   = shift_q[Word_Length-1 -: Chunk_Width];
    assign out_last   = (state_q == S_SEND) && (cnt_q == LastCnt);
    assign done       = done_q;
    assign load_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);

endmodule
